// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises icache refills and dcache refills/writebacks
// onto one line-wide main-memory port, one outstanding transaction at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_rdy_o,
  output logic [LINE_WIDTH-1:0] ic_line_o,
  input  logic                  dc_req_i,
  input  logic                  dc_we_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_WIDTH-1:0] dc_wdata_i,
  output logic                  dc_rdy_o,
  output logic [LINE_WIDTH-1:0] dc_line_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [LINE_WIDTH-1:0] mem_rdata_i
);

  localparam int LINE_OFFS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_q;
  logic                   ownerDc_q;
  logic                   memReq_q;
  logic                   memWe_q;
  logic [ADDR_WIDTH-1:0]  memAddr_q;
  logic [LINE_WIDTH-1:0]  memWdata_q;
  logic                   icRdy_q;
  logic                   dcRdy_q;
  logic [LINE_WIDTH-1:0]  icLine_q;
  logic [LINE_WIDTH-1:0]  dcLine_q;

  logic                   grantValid_d;
  logic                   grantDc_d;
  logic                   grantWe_d;
  logic [ADDR_WIDTH-1:0]  grantAddr_d;
  logic [LINE_WIDTH-1:0]  grantWdata_d;

  // On a conflict the side that did not win last time gets the port.
  always_comb begin
    grantValid_d = ic_req_i | dc_req_i;
    grantDc_d    = dc_req_i & (~ic_req_i | ~ownerDc_q);
    grantWe_d    = grantDc_d & dc_we_i;
    grantAddr_d  = (grantDc_d ? dc_addr_i : ic_addr_i) & ADDR_MASK;
    grantWdata_d = grantWe_d ? dc_wdata_i : '0;
  end

  // ownerDc_q doubles as last_grant: the owner of a transaction is always the last side granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ownerDc_q  <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      icRdy_q    <= 1'b0;
      dcRdy_q    <= 1'b0;
      icLine_q   <= '0;
      dcLine_q   <= '0;
    end else begin
      icRdy_q <= 1'b0;
      dcRdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid_d) begin
            ownerDc_q  <= grantDc_d;
            memReq_q   <= 1'b1;
            memWe_q    <= grantWe_d;
            memAddr_q  <= grantAddr_d;
            memWdata_q <= grantWdata_d;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!memWe_q) begin
              if (ownerDc_q) dcLine_q <= mem_rdata_i;
              else           icLine_q <= mem_rdata_i;
            end
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            icRdy_q    <= ~ownerDc_q;
            dcRdy_q    <= ownerDc_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ic_rdy_o    = icRdy_q;
  assign dc_rdy_o    = dcRdy_q;
  assign ic_line_o   = icLine_q;
  assign dc_line_o   = dcLine_q;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected memory requests and rdy
// responses into queues; a memory model and an rdy monitor pop and compare them.
module tb_mem_arbiter;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;
  } memExp_t;

  typedef struct {
    logic         isDc;
    logic [127:0] icLine;
    logic [127:0] dcLine;
  } rdyExp_t;

  logic         clk;
  logic         rst;
  logic         icReq;
  logic [31:0]  icAddr;
  logic         icRdy;
  logic [127:0] icLine;
  logic         dcReq;
  logic         dcWe;
  logic [31:0]  dcAddr;
  logic [127:0] dcWdata;
  logic         dcRdy;
  logic [127:0] dcLine;
  logic         memReq;
  logic         memWe;
  logic [31:0]  memAddr;
  logic [127:0] memWdata;
  logic         memAck;
  logic [127:0] memRdata;

  logic         modelAck;
  logic         forceAck;
  logic         memHold;
  logic         monOn;
  int           cyc = 0;
  int           compared = 0;
  int           mismatched = 0;
  logic [127:0] icLineM;
  logic [127:0] dcLineM;
  memExp_t      memQ[$];
  rdyExp_t      rdyQ[$];
  int           startQ[$];
  memExp_t      memE;
  rdyExp_t      rdyE;

  assign memAck = modelAck | forceAck;

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .ic_req_i   (icReq),
    .ic_addr_i  (icAddr),
    .ic_rdy_o   (icRdy),
    .ic_line_o  (icLine),
    .dc_req_i   (dcReq),
    .dc_we_i    (dcWe),
    .dc_addr_i  (dcAddr),
    .dc_wdata_i (dcWdata),
    .dc_rdy_o   (dcRdy),
    .dc_line_o  (dcLine),
    .mem_req_o  (memReq),
    .mem_we_o   (memWe),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_ack_i  (memAck),
    .mem_rdata_i(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expectTxn(input logic isDc, input logic we, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [127:0] rdata, input int delay);
    memExp_t m;
    rdyExp_t r;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.delay = delay;
    memQ.push_back(m);
    if (!we) begin
      if (isDc) dcLineM = rdata;
      else      icLineM = rdata;
    end
    r.isDc = isDc; r.icLine = icLineM; r.dcLine = dcLineM;
    rdyQ.push_back(r);
  endtask

  // Called #1 after a posedge; drops req at the edge that follows the observed rdy.
  task automatic applyStimulus(input logic isDc, input logic we, input logic [31:0] addr,
                               input logic [127:0] wdata, input int count, input int expLat);
    int  t0;
    bit  got;
    for (int n = 0; n < count; n++) begin
      if (isDc) begin
        dcReq = 1'b1; dcWe = we; dcAddr = addr; dcWdata = wdata;
      end else begin
        icReq = 1'b1; icAddr = addr;
      end
      t0  = cyc;
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if (isDc ? dcRdy : icRdy) got = 1'b1;
      end
      checkOutput(isDc ? "dc_rdy_seen" : "ic_rdy_seen", got, 1);
      if (got && expLat >= 0) checkOutput("req_to_rdy_latency", cyc - t0, expLat);
      @(posedge clk);
      #1;
      if (isDc) dcReq = 1'b0;
      else      icReq = 1'b0;
    end
  endtask

  // Memory model: checks each request against the scoreboard and acks after its delay.
  initial begin
    modelAck = 1'b0;
    memRdata = '0;
    forever begin
      @(negedge clk);
      if (rst && memReq && !memHold) begin
        startQ.push_back(cyc);
        if (memQ.size() == 0) begin
          checkOutput("unexpected_mem_req", memReq, 0);
          @(posedge clk);
        end else begin
          memE = memQ.pop_front();
          checkOutput("mem_we", memWe, memE.we);
          checkOutput("mem_addr", memAddr, memE.addr);
          if (memE.we) checkOutput("mem_wdata", memWdata, memE.wdata);
          repeat (memE.delay) @(negedge clk);
          checkOutput("mem_req_held", {memReq, memAddr}, {1'b1, memE.addr});
          memRdata = memE.rdata;
          modelAck = 1'b1;
          @(posedge clk);
          #1;
          modelAck = 1'b0;
          memRdata = {4{32'hBAD0BAD0}};
        end
      end
    end
  end

  // Rdy monitor: every pulse must match the next scoreboard entry; idle port must be quiet.
  always @(negedge clk) begin
    if (monOn && rst) begin
      if (icRdy || dcRdy) begin
        if (rdyQ.size() == 0) begin
          checkOutput("unexpected_rdy", {icRdy, dcRdy}, 0);
        end else begin
          rdyE = rdyQ.pop_front();
          checkOutput("rdy_side", {icRdy, dcRdy}, rdyE.isDc ? 2'b01 : 2'b10);
          checkOutput("ic_line", icLine, rdyE.icLine);
          checkOutput("dc_line", dcLine, rdyE.dcLine);
        end
      end
      if (!memReq) checkOutput("idle_port_zero", {memWe, memAddr, memWdata}, 0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    bit seen;
    rst = 1'b0; monOn = 1'b0; memHold = 1'b0; forceAck = 1'b0;
    icReq = 1'b0; icAddr = '0; dcReq = 1'b0; dcWe = 1'b0; dcAddr = '0; dcWdata = '0;
    icLineM = '0; dcLineM = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      icReq = 1'($urandom); dcReq = 1'($urandom); dcWe = 1'($urandom);
      icAddr = $urandom; dcAddr = $urandom; dcWdata = {4{$urandom}};
      forceAck = 1'($urandom);
      @(negedge clk);
      checkOutput("reset_ctrl", {icRdy, dcRdy, memReq, memWe}, 0);
      checkOutput("reset_addr", memAddr, 0);
      checkOutput("reset_wdata", memWdata, 0);
      checkOutput("reset_lines", {icLine, dcLine}, 0);
    end
    @(posedge clk);
    #1;
    icReq = 1'b0; dcReq = 1'b0; dcWe = 1'b0; icAddr = '0; dcAddr = '0; dcWdata = '0;
    forceAck = 1'b0; rst = 1'b1; monOn = 1'b1;
    $display("[TB] reset released");

    expectTxn(1, 0, 32'h0000_2000, '0, {4{32'h1111_0001}}, 1);
    expectTxn(0, 0, 32'h0000_3000, '0, {4{32'h2222_0002}}, 2);
    expectTxn(1, 0, 32'h0000_2000, '0, {4{32'h3333_0003}}, 0);
    expectTxn(0, 0, 32'h0000_3000, '0, {4{32'h4444_0004}}, 3);
    fork
      applyStimulus(1, 0, 32'h0000_2008, {4{32'h5555_5555}}, 2, -1);
      applyStimulus(0, 0, 32'h0000_3004, '0, 2, -1);
    join
    $display("[TB] conflict sequence done");

    expectTxn(0, 0, 32'h0000_1230, '0, 128'hDEADBEEF_00000000_CAFEBABE_12345678, 5);
    applyStimulus(0, 0, 32'h0000_1234, '0, 1, 7);

    expectTxn(1, 1, 32'h8000_00F0, {16{8'hA5}}, {4{32'hFFFF_FFFF}}, 2);
    applyStimulus(1, 1, 32'h8000_00FF, {16{8'hA5}}, 1, 4);
    dcWe = 1'b0;

    expectTxn(0, 0, 32'h0000_0040, '0, {4{32'h6666_0006}}, 0);
    expectTxn(0, 0, 32'h0000_0040, '0, {4{32'h7777_0007}}, 0);
    applyStimulus(0, 0, 32'h0000_0044, '0, 2, 2);
    gap = startQ[startQ.size() - 1] - startQ[startQ.size() - 2];
    checkOutput("grant_gap_ge3", gap >= 3, 1);

    memHold = 1'b1;
    icAddr = 32'h0000_7770;
    icReq = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (memReq) seen = 1'b1;
    end
    checkOutput("midrst_busy", seen, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; icReq = 1'b0; forceAck = 1'b1;
    icLineM = '0; dcLineM = '0;
    @(negedge clk);
    checkOutput("midrst_req_drop", memReq, 0);
    @(posedge clk);
    #1;
    forceAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_quiet", {memReq, icRdy, dcRdy}, 0);
    end
    memHold = 1'b0;
    @(posedge clk);
    #1;

    expectTxn(0, 0, 32'h0000_0100, '0, {4{32'h8888_0008}}, 1);
    applyStimulus(0, 0, 32'h0000_0108, '0, 1, 3);

    repeat (3) @(posedge clk);
    checkOutput("queues_drained", {memQ.size(), rdyQ.size()}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
